// File: rtl/bram_sdp_be_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bram_sdp_be_pkg                                            |
// | Brief   : Shared constants for the byte-enable simple dual-port RAM  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package bram_sdp_be_pkg;

    localparam int       c_STATE_W  = 1;
    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bram_clear_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bram_clear_ctrl                                            |
// | Brief   : Power-on clear FSM; owns the RAM write port mux            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bram_clear_ctrl
    import bram_sdp_be_pkg::*;
#(
    parameter  int DEPTH          = 1024,
    parameter  int DATA_W         = 32,
    parameter  int BYTE_W         = 8,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int AW             = $clog2(DEPTH),
    localparam int NB             = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NB-1:0]     wr_be,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic              init_busy,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [NB-1:0]     mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              rd_ok
);

    localparam logic [AW:0]          c_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]        c_LAST    = AW'(DEPTH - 1);
    localparam logic [c_STATE_W-1:0] c_ST_INIT = (CLEAR_ON_RESET != 0) ? c_ST_CLEAR : c_ST_READY;

    logic [c_STATE_W-1:0] r_state;
    logic [AW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 w_wr_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_INIT;
            r_cnt   <= '0;
            r_busy  <= (CLEAR_ON_RESET != 0);
        end else if (r_state == c_ST_CLEAR) begin
            if (r_cnt == c_LAST) begin
                r_state <= c_ST_READY;
                r_busy  <= 1'b0;
            end else begin
                r_cnt <= r_cnt + AW'(1);
            end
        end
    end

    assign w_wr_in_range = ({1'b0, wr_addr} < c_DEPTH);

    // While clearing, the counter owns the write port and user traffic is discarded.
    always_comb begin
        mem_we    = 1'b1;
        mem_addr  = r_cnt;
        mem_be    = '1;
        mem_wdata = '0;
        if (!r_busy) begin
            mem_we    = wr_en & w_wr_in_range & (|wr_be);
            mem_addr  = wr_addr;
            mem_be    = wr_be;
            mem_wdata = wr_data;
        end
    end

    assign rd_ok     = rd_en & ~r_busy;
    assign init_busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/bram_sdp_be.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bram_sdp_be                                                |
// | Brief   : Simple dual-port block RAM with byte enables, 1/2-cycle    |
// |           read latency, collision bypass and power-on clear          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bram_sdp_be
    import bram_sdp_be_pkg::*;
#(
    parameter  int DEPTH          = 1024,
    parameter  int DATA_W         = 32,
    parameter  int BYTE_W         = 8,
    parameter  int READ_LATENCY   = 1,
    parameter  int WRITE_FIRST    = 0,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int AW             = $clog2(DEPTH),
    localparam int NB             = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NB-1:0]     wr_be,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("bram_sdp_be: READ_LATENCY must be 1 or 2");
    end
    if ((DATA_W % BYTE_W) != 0 || DEPTH < 2) begin : g_bad_geometry
        $error("bram_sdp_be: DATA_W must be a multiple of BYTE_W and DEPTH >= 2");
    end

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic              w_mem_we;
    logic [AW-1:0]     w_mem_addr;
    logic [NB-1:0]     w_mem_be;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_rd_ok;
    logic              w_rd_in_range;
    logic              w_hit;
    logic [DATA_W-1:0] w_merged;

    logic              r_v1;
    logic [DATA_W-1:0] r_q1;
    logic              r_hit;
    logic [NB-1:0]     r_byp_be;
    logic [DATA_W-1:0] r_byp_data;

    (* ram_style = "block" *) logic [DATA_W-1:0] r_mem [DEPTH];

    bram_clear_ctrl #(
        .DEPTH          (DEPTH),
        .DATA_W         (DATA_W),
        .BYTE_W         (BYTE_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .init_busy (init_busy),
        .mem_we    (w_mem_we),
        .mem_addr  (w_mem_addr),
        .mem_be    (w_mem_be),
        .mem_wdata (w_mem_wdata),
        .rd_ok     (w_rd_ok)
    );

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (w_mem_be[i]) begin
                    r_mem[w_mem_addr][i*BYTE_W +: BYTE_W] <= w_mem_wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign w_rd_in_range = ({1'b0, rd_addr} < c_DEPTH);
    // w_mem_we is already qualified by range and readiness, so an address match is a real collision.
    assign w_hit = (WRITE_FIRST != 0) && w_rd_ok && w_mem_we && (w_mem_addr == rd_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1       <= 1'b0;
            r_q1       <= '0;
            r_hit      <= 1'b0;
            r_byp_be   <= '0;
            r_byp_data <= '0;
        end else begin
            r_v1 <= w_rd_ok;
            if (w_rd_ok) begin
                r_q1       <= w_rd_in_range ? r_mem[rd_addr] : '0;
                r_hit      <= w_hit;
                r_byp_be   <= w_mem_be;
                r_byp_data <= w_mem_wdata;
            end
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_merge
        assign w_merged[g*BYTE_W +: BYTE_W] = (r_hit && r_byp_be[g]) ?
            r_byp_data[g*BYTE_W +: BYTE_W] : r_q1[g*BYTE_W +: BYTE_W];
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic              r_v2;
        logic [DATA_W-1:0] r_q2;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v2 <= 1'b0;
                r_q2 <= '0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_q2 <= w_merged;
                end
            end
        end
        assign rd_valid = r_v2;
        assign rd_data  = r_q2;
    end else begin : g_lat1
        assign rd_valid = r_v1;
        assign rd_data  = w_merged;
    end

endmodule
`default_nettype wire
